// File: rtl/bg_rect_fill_pkg.sv
// Shared frame-buffer constants and fill FSM encoding used by every
// background frame-buffer reader and writer.
package bg_rect_fill_pkg;

  localparam int unsigned H_RES     = 160;
  localparam int unsigned V_RES     = 120;
  localparam int unsigned FB_ADDR_W = 15;
  localparam int unsigned FB_DEPTH  = H_RES * V_RES;
  localparam int unsigned COORD_W   = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } fill_state_e;

endpackage

// File: rtl/bg_rect_fill_if.sv
// Request and background-RAM write-port bundle of the rectangle filler.
interface bg_rect_fill_if;
  import bg_rect_fill_pkg::*;

  logic                 start;
  logic [COORD_W-1:0]   x0;
  logic [COORD_W-1:0]   y0;
  logic [COORD_W-1:0]   w;
  logic [COORD_W-1:0]   h;
  logic                 value;
  logic [FB_ADDR_W-1:0] address;
  logic                 data;
  logic                 wren;
  logic                 busy;
  logic                 done;

  modport master (
    output start, x0, y0, w, h, value,
    input  address, data, wren, busy, done
  );

  modport slave (
    input  start, x0, y0, w, h, value,
    output address, data, wren, busy, done
  );

endinterface

// File: rtl/bg_addr_calc.sv
// Pixel coordinate to linear frame-buffer address (cx + cy * line width).
module bg_addr_calc
  import bg_rect_fill_pkg::*;
#(
  parameter int unsigned LineW = H_RES
) (
  input  logic [COORD_W-1:0]   cx,
  input  logic [COORD_W-1:0]   cy,
  output logic [FB_ADDR_W-1:0] address
);

  localparam logic [FB_ADDR_W-1:0] LineWV = FB_ADDR_W'(LineW);

  assign address = FB_ADDR_W'(cx) + FB_ADDR_W'(cy) * LineWV;

endmodule

// File: rtl/bg_rect_fill.sv
// Fills a clipped rectangle of the 1-bit background RAM in raster order,
// one write per cycle, with fully registered outputs.
module bg_rect_fill #(
  parameter int unsigned H_RES = bg_rect_fill_pkg::H_RES,
  parameter int unsigned V_RES = bg_rect_fill_pkg::V_RES
) (
  input  logic          clk,
  input  logic          reset,
  bg_rect_fill_if.slave fb
);
  import bg_rect_fill_pkg::*;

  fill_state_e          state_q, state_d;
  logic [COORD_W-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic [COORD_W-1:0]   x0_q, x0_d, xe_q, xe_d, ye_q, ye_d;
  logic                 data_q, data_d;
  logic                 degen_q, degen_d;
  logic                 wren_q, busy_q, done_q;
  logic [FB_ADDR_W-1:0] address_q, addr_d;

  logic [COORD_W:0]     x_lim, y_lim;
  logic                 req_ok;

  // 9-bit extent arithmetic so x0 + w never wraps before clipping.
  always_comb begin
    x_lim = {1'b0, fb.x0} + {1'b0, fb.w};
    y_lim = {1'b0, fb.y0} + {1'b0, fb.h};
    if (x_lim > 9'(H_RES)) x_lim = 9'(H_RES);
    if (y_lim > 9'(V_RES)) y_lim = 9'(V_RES);
    req_ok = (fb.w != '0) && (fb.h != '0) &&
             ({1'b0, fb.x0} < 9'(H_RES)) && ({1'b0, fb.y0} < 9'(V_RES));
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    x0_d    = x0_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    data_d  = data_q;
    degen_d = degen_q;
    unique case (state_q)
      StIdle: begin
        if (fb.start) begin
          if (req_ok) begin
            state_d = StFill;
            cx_d    = fb.x0;
            cy_d    = fb.y0;
            x0_d    = fb.x0;
            xe_d    = COORD_W'(x_lim - 9'd1);
            ye_d    = COORD_W'(y_lim - 9'd1);
            data_d  = fb.value;
          end else begin
            // Degenerate request: spend one silent DONE cycle so the done
            // pulse lands at the same latency as a single-pixel fill.
            state_d = StDone;
            degen_d = 1'b1;
          end
        end
      end
      StFill: begin
        if (cx_q == xe_q) begin
          if (cy_q == ye_q) begin
            state_d = StDone;
          end else begin
            cx_d = x0_q;
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      StDone: begin
        if (degen_q) degen_d = 1'b0;
        else         state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Address is computed from the next coordinates so it can be registered
  // alongside wren; coordinates hold on the last pixel, so address holds too.
  bg_addr_calc #(
    .LineW(H_RES)
  ) u_addr_calc (
    .cx     (cx_d),
    .cy     (cy_d),
    .address(addr_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cx_q      <= '0;
      cy_q      <= '0;
      x0_q      <= '0;
      xe_q      <= '0;
      ye_q      <= '0;
      data_q    <= 1'b0;
      degen_q   <= 1'b0;
      wren_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      address_q <= '0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      x0_q      <= x0_d;
      xe_q      <= xe_d;
      ye_q      <= ye_d;
      data_q    <= data_d;
      degen_q   <= degen_d;
      wren_q    <= (state_d == StFill);
      busy_q    <= (state_d == StFill);
      done_q    <= (state_d == StDone) && !degen_d;
      address_q <= addr_d;
    end
  end

  assign fb.address = address_q;
  assign fb.data    = data_q;
  assign fb.wren    = wren_q;
  assign fb.busy    = busy_q;
  assign fb.done    = done_q;

endmodule

// File: tb/tb_bg_rect_fill.sv
// Self-checking bench for bg_rect_fill: directed table, randomized requests,
// start-while-busy, reset abort and a full-frame RAM scoreboard.
module tb_bg_rect_fill;
  import bg_rect_fill_pkg::*;

  localparam int HR  = 160;
  localparam int VR  = 120;
  localparam int DEP = HR * VR;

  logic clk;
  logic reset;
  bg_rect_fill_if bus ();

  bg_rect_fill #(
    .H_RES(HR),
    .V_RES(VR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .fb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hold_addr = 0;
  int hold_data = 0;
  int wcount [DEP];
  bit ram [DEP];

  typedef struct {
    int x0; int y0; int w; int h; int val;
    int n; int first; int last;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Applies one request and checks every following cycle against a model
  // built from the raster-scan rules with plain nested loops.
  task automatic run_req(input int x0, input int y0, input int w, input int h, input int val,
                         input bit poke, input bit sb,
                         output int n_act, output int first_a, output int last_a);
    int q[$];
    int n, dc, lim, nh_addr, nh_data;
    int wr_cnt, wren_err, addr_err, data_err, busy_err, done_cnt, done_err, hold_err, oob;
    q.delete();
    for (int y = y0; y < y0 + h && y < VR; y++)
      for (int x = x0; x < x0 + w && x < HR; x++)
        q.push_back(y * HR + x);
    n  = q.size();
    dc = (n == 0) ? 2 : n + 1;
    lim = dc + 3;
    nh_addr = (n > 0) ? q[n-1] : hold_addr;
    nh_data = (n > 0) ? (val & 1) : hold_data;
    wr_cnt = 0; wren_err = 0; addr_err = 0; data_err = 0; busy_err = 0;
    done_cnt = 0; done_err = 0; hold_err = 0; oob = 0;
    first_a = -1; last_a = -1;
    if (sb) for (int i = 0; i < DEP; i++) begin wcount[i] = 0; ram[i] = 1'b1; end

    @(negedge clk);
    bus.start = 1'b1;
    bus.x0 = x0[7:0]; bus.y0 = y0[7:0]; bus.w = w[7:0]; bus.h = h[7:0];
    bus.value = val[0];
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      if (bus.wren) begin
        wr_cnt++;
        if (first_a < 0) first_a = int'(bus.address);
        last_a = int'(bus.address);
        if (int'(bus.address) >= DEP) oob++;
        else if (sb) begin wcount[bus.address]++; ram[bus.address] = bus.data; end
        if (k <= n && int'(bus.address) != q[k-1]) addr_err++;
        if (int'(bus.data) != (val & 1)) data_err++;
      end else if (k > n) begin
        if (int'(bus.address) != nh_addr || int'(bus.data) != nh_data) hold_err++;
      end
      if (bus.wren != (k <= n)) wren_err++;
      if (bus.busy != (k <= n)) busy_err++;
      if (bus.done) begin
        done_cnt++;
        if (k != dc) done_err++;
      end
      // Scramble request fields after the start cycle; optionally hold start
      // high through every FILL/DONE cycle, where it must be ignored.
      if (k == 1) begin
        bus.start = poke;
        bus.x0 = 8'($urandom); bus.y0 = 8'($urandom);
        bus.w = 8'($urandom); bus.h = 8'($urandom); bus.value = 1'($urandom);
      end
      if (k == dc + 1) bus.start = 1'b0;
    end
    check("writes", wr_cnt, n);
    check("wren_timing", wren_err, 0);
    check("addr_seq", addr_err, 0);
    check("data", data_err, 0);
    check("busy", busy_err, 0);
    check("done_count", done_cnt, 1);
    check("done_timing", done_err, 0);
    check("hold", hold_err, 0);
    check("oob", oob, 0);
    hold_addr = nh_addr;
    hold_data = nh_data;
    n_act = wr_cnt;
  endtask

  initial begin
    int na, fa, la, bad, wcnt, rx0, ry0, rw, rh;
    bit hit;
    vecs[0] = '{x0:0,   y0:0,   w:1,   h:1, val:1, n:1,   first:0,     last:0};
    vecs[1] = '{x0:10,  y0:5,   w:3,   h:2, val:1, n:6,   first:810,   last:972};
    vecs[2] = '{x0:158, y0:118, w:5,   h:5, val:0, n:4,   first:19038, last:19199};
    vecs[3] = '{x0:0,   y0:0,   w:0,   h:5, val:1, n:0,   first:-1,    last:-1};
    vecs[4] = '{x0:160, y0:0,   w:4,   h:4, val:1, n:0,   first:-1,    last:-1};
    vecs[5] = '{x0:5,   y0:120, w:2,   h:2, val:1, n:0,   first:-1,    last:-1};
    vecs[6] = '{x0:159, y0:119, w:1,   h:1, val:1, n:1,   first:19199, last:19199};
    vecs[7] = '{x0:0,   y0:7,   w:160, h:1, val:0, n:160, first:1120,  last:1279};

    reset = 1'b1;
    bus.start = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.w = '0; bus.h = '0; bus.value = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_address", int'(bus.address), 0);
    check("rst_data", int'(bus.data), 0);
    check("rst_wren", int'(bus.wren), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    @(negedge clk);
    reset = 1'b0;
    hold_addr = 0; hold_data = 0;

    for (int i = 0; i < 8; i++) begin
      run_req(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].val, 1'b0, 1'b0, na, fa, la);
      check($sformatf("vec%0d_n", i), na, vecs[i].n);
      check($sformatf("vec%0d_first", i), fa, vecs[i].first);
      check($sformatf("vec%0d_last", i), la, vecs[i].last);
    end

    // Randomized requests, including far off-frame and oversized extents.
    for (int i = 0; i < 24; i++) begin
      rx0 = $urandom_range(0, 170);
      ry0 = $urandom_range(0, 125);
      if (i % 3 == 0) begin rw = $urandom_range(0, 255); rh = $urandom_range(0, 10); end
      else            begin rw = $urandom_range(0, 24);  rh = $urandom_range(0, 24); end
      if (i % 8 == 7) begin rx0 = $urandom_range(150, 255); rw = $urandom_range(100, 255); end
      run_req(rx0, ry0, rw, rh, int'($urandom_range(0, 1)), 1'(i % 2), 1'b0, na, fa, la);
    end

    // Full frame with start held during the fill, plus RAM scoreboard.
    run_req(0, 0, 160, 120, 0, 1'b1, 1'b1, na, fa, la);
    bad = 0;
    for (int a = 0; a < DEP; a++) if (wcount[a] != 1 || ram[a] != 1'b0) bad++;
    check("ram_once", bad, 0);

    // Abort a full-frame fill with reset at the 100th write.
    @(negedge clk);
    bus.start = 1'b1; bus.x0 = 8'd0; bus.y0 = 8'd0; bus.w = 8'd160; bus.h = 8'd120;
    bus.value = 1'b1;
    wcnt = 0; hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.wren) wcnt++;
      if (wcnt == 100) begin reset = 1'b1; hit = 1'b1; end
    end
    check("abort_reached", int'(hit), 1);
    @(posedge clk);
    #1;
    check("abort_wren", int'(bus.wren), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_addr", int'(bus.address), 0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done || bus.wren || bus.busy) bad++;
    end
    check("abort_quiet", bad, 0);
    hold_addr = 0; hold_data = 0;
    run_req(3, 4, 2, 2, 1, 1'b0, 1'b0, na, fa, la);
    check("fresh_first", fa, 643);
    check("fresh_last", la, 804);

    // Reset wins over start in the same cycle.
    @(negedge clk);
    reset = 1'b1; bus.start = 1'b1; bus.w = 8'd4; bus.h = 8'd4; bus.x0 = 8'd1; bus.y0 = 8'd1;
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.wren || bus.busy || bus.done) bad++;
    end
    check("reset_priority", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bg_rect_fill.md
BG_RECT_FILL -- requirements
Module: bg_rect_fill

Interface
REQ-001 H_RES, default 160, shall set the frame width in pixels.
REQ-002 V_RES, default 120, shall set the frame height in pixels.
REQ-003 clk  in  1  shall be the single clock; all state updates occur on its rising edge.
REQ-004 reset  in  1  shall be the synchronous, active-high reset.
REQ-005 start  in  1  shall be a one-cycle fill request, sampled only in IDLE.
REQ-006 x0, y0  in  8 each  shall give the top-left pixel of the rectangle.
REQ-007 w, h  in  8 each  shall give the rectangle width and height in pixels.
REQ-008 value  in  1  shall give the pixel value to write.
REQ-009 address  out  15  shall carry the background-RAM write address.
REQ-010 data  out  1  shall carry the background-RAM write data.
REQ-011 wren  out  1  shall be the background-RAM write enable.
REQ-012 busy  out  1  shall be high while a fill is in progress.
REQ-013 done  out  1  shall pulse high for one cycle when a fill completes.

Function
REQ-014 On start in IDLE, the block shall latch x0, y0, value and the clipped extents; later input changes shall not affect the fill.
- xe = min(x0+w, H_RES) - 1
- ye = min(y0+h, V_RES) - 1
- Extent arithmetic is 9-bit, so no overflow occurs.
REQ-015 FSM states shall be IDLE, FILL and DONE.
- IDLE->FILL on start with w>0, h>0, x0<H_RES and y0<V_RES.
- IDLE->DONE on start otherwise (degenerate request).
REQ-016 In FILL, the block shall issue exactly one write per cycle with wren=1, data=value and address = cx + cy*H_RES.
REQ-017 The first write shall occur in the cycle after start is sampled, at (cx,cy) = (x0,y0).
REQ-018 The scan shall be raster order:
- cx increments each cycle.
- At cx==xe, cx returns to x0 and cy increments.
- At cx==xe and cy==ye, the FSM goes to DONE.
REQ-019 A w x h in-frame fill shall produce exactly w*h write cycles, with no gaps and no duplicates.
REQ-020 DONE shall last one cycle with done=1, wren=0 and busy=0, then return to IDLE.
REQ-021 busy shall be 1 exactly in FILL.
REQ-022 wren shall be 0 in IDLE and DONE.
REQ-023 address and data shall hold their last values when wren=0.
REQ-024 start asserted in FILL or DONE shall be ignored; it is neither queued nor allowed to alter the fill.
REQ-025 A degenerate request (w=0, h=0, or origin off-frame) shall produce zero writes and a done pulse two cycles after start is sampled.
REQ-026 A rectangle crossing the right or bottom edge shall be clipped; no address >= H_RES*V_RES shall ever be driven with wren=1.
REQ-027 Outputs shall be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 reset shall force:
- state=IDLE
- wren=0, busy=0, done=0
- address=0, data=0
- internal cx, cy, xe, ye = 0
REQ-029 Reset asserted mid-fill shall abort the fill. wren shall be 0 from the first edge with reset high, and no done pulse shall be produced.
REQ-030 reset shall take priority over start in the same cycle.

Structure
REQ-031 A shared package shall hold the frame constants used by every frame-buffer reader and writer:
- H_RES=160, V_RES=120
- FB_ADDR_W=15
- FB_DEPTH=19200
- The FSM state enumeration
REQ-032 The address computation (cx + cy*H_RES, 15-bit) shall be one sub-module, bg_addr_calc, shared with the framebuffer scanners.
REQ-033 The block shall connect to the write port of the 1-bit background RAM (address, data, wren) and shall not read the RAM.

Verification
REQ-034 Reset, then start with x0=0, y0=0, w=1, h=1, value=1 -> exactly one write, at address 0 with data 1, one cycle after start; done two cycles after start.
REQ-035 start with x0=10, y0=5, w=3, h=2, value=1 -> 6 writes at 810, 811, 812, 970, 971, 972 in consecutive cycles; busy high for 6 cycles.
REQ-036 start with x0=158, y0=118, w=5, h=5 -> writes only at 19038, 19039, 19198, 19199; no address >= 19200.
REQ-037 start with w=0 (also with x0=160) -> no writes, done pulse two cycles after start, busy never high.
REQ-038 Second start during a 0,0,160,120 fill -> ignored, and exactly 19200 writes occur. A separate run asserts reset at write 100 -> wren=0 on the next edge, no done, and a following start runs a fresh fill.
REQ-039 Full-frame fill 0,0,160,120 value=0 -> every address 0..19199 written exactly once, checked by a scoreboard against a RAM model.
